sync_analyzer: RTL and testbench

//  Receive-side counterpart of crtc. Watches hsync/vsync/hden/vden on the dot-clock domain and recovers
//  the timing registers that produced them. Also regenerates a local beam position (x_o, y_o) and

---
 rtl/sync_analyzer.sv | 161 ++++++++++++++++
 tb/tb_sync_analyzer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/sync_analyzer.sv
// Recovers crtc timing registers from hsync/vsync/hden/vden, regenerates the beam
// position, and publishes a measurement set once per frame with a stability lock.
module sync_analyzer #(
    parameter int W           = 10,
    parameter int LOCK_FRAMES = 2
) (
    input  logic         dotclk_i,
    input  logic         reset_ni,
    input  logic         hsync_i,
    input  logic         vsync_i,
    input  logic         hden_i,
    input  logic         vden_i,
    output logic [W-1:0] x_o,
    output logic [W-1:0] y_o,
    output logic [W-1:0] htotal_o,
    output logic [W-1:0] hsstart_o,
    output logic [W-1:0] hvstart_o,
    output logic [W-1:0] hvend_o,
    output logic [W-1:0] vtotal_o,
    output logic [W-1:0] vsstart_o,
    output logic [W-1:0] vvstart_o,
    output logic [W-1:0] vvend_o,
    output logic         frame_o,
    output logic         locked_o
);
    localparam logic [W-1:0] C_MAX  = {W{1'b1}};
    localparam logic [3:0]   C_LOCK = 4'(LOCK_FRAMES);

    typedef enum logic {SEEK, RUN} state_t;
    state_t r_state;

    logic         r_hs_q, r_vs_q, r_hd_q, r_vd_q;
    logic         w_hs_rise, w_hs_fall, w_vs_rise, w_vs_fall;
    logic         w_hd_rise, w_hd_fall, w_vd_rise, w_vd_fall;
    logic [W-1:0] w_x_nx, w_y_nx;
    logic [W-1:0] r_sh_htotal, r_sh_hsstart, r_sh_hvstart, r_sh_hvend;
    logic [W-1:0] r_sh_vsstart, r_sh_vvstart, r_sh_vvend;
    logic [3:0]   r_match, w_match_nx;
    logic         w_same, w_timeout;

    always_ff @(posedge dotclk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_hs_q <= 1'b0;
            r_vs_q <= 1'b0;
            r_hd_q <= 1'b0;
            r_vd_q <= 1'b0;
        end else begin
            r_hs_q <= hsync_i;
            r_vs_q <= vsync_i;
            r_hd_q <= hden_i;
            r_vd_q <= vden_i;
        end
    end

    assign w_hs_rise = hsync_i & ~r_hs_q;
    assign w_hs_fall = ~hsync_i & r_hs_q;
    assign w_vs_rise = vsync_i & ~r_vs_q;
    assign w_vs_fall = ~vsync_i & r_vs_q;
    assign w_hd_rise = hden_i & ~r_hd_q;
    assign w_hd_fall = ~hden_i & r_hd_q;
    assign w_vd_rise = vden_i & ~r_vd_q;
    assign w_vd_fall = ~vden_i & r_vd_q;

    // Both counters saturate so a dead input shows up as a timeout instead of wrapping.
    assign w_x_nx = w_hs_fall ? '0 : (x_o == C_MAX) ? x_o : x_o + W'(1);
    assign w_y_nx = w_vs_fall ? '0 :
                    (w_hs_fall && (y_o != C_MAX)) ? y_o + W'(1) : y_o;

    assign w_timeout = (x_o == C_MAX) || (y_o == C_MAX);

    always_ff @(posedge dotclk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            x_o <= '0;
            y_o <= '0;
        end else begin
            x_o <= w_x_nx;
            y_o <= w_y_nx;
        end
    end

    // Leaving SEEK discards horizontal captures taken while unaligned; a capture
    // in that same cycle still lands because it is written after the clear.
    always_ff @(posedge dotclk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_sh_htotal  <= '0;
            r_sh_hsstart <= '0;
            r_sh_hvstart <= '0;
            r_sh_hvend   <= '0;
            r_sh_vsstart <= '0;
            r_sh_vvstart <= '0;
            r_sh_vvend   <= '0;
        end else begin
            if (r_state == SEEK && w_vs_fall) begin
                r_sh_hsstart <= '0;
                r_sh_hvstart <= '0;
                r_sh_hvend   <= '0;
            end
            if (w_hs_fall) r_sh_htotal  <= x_o;
            if (w_hs_rise) r_sh_hsstart <= w_x_nx;
            if (w_hd_rise) r_sh_hvstart <= w_x_nx;
            if (w_hd_fall) r_sh_hvend   <= w_x_nx;
            if (w_vs_rise) r_sh_vsstart <= w_y_nx;
            if (w_vd_rise) r_sh_vvstart <= w_y_nx;
            if (w_vd_fall) r_sh_vvend   <= w_y_nx;
        end
    end

    // vtotal is taken straight from y_o on the publishing vs fall, so it needs no shadow.
    assign w_same = {r_sh_htotal, r_sh_hsstart, r_sh_hvstart, r_sh_hvend,
                     y_o, r_sh_vsstart, r_sh_vvstart, r_sh_vvend} ==
                    {htotal_o, hsstart_o, hvstart_o, hvend_o,
                     vtotal_o, vsstart_o, vvstart_o, vvend_o};

    assign w_match_nx = !w_same ? 4'd0 :
                        (r_match >= C_LOCK) ? C_LOCK : r_match + 4'd1;

    always_ff @(posedge dotclk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state   <= SEEK;
            r_match   <= 4'd0;
            frame_o   <= 1'b0;
            locked_o  <= 1'b0;
            htotal_o  <= '0;
            hsstart_o <= '0;
            hvstart_o <= '0;
            hvend_o   <= '0;
            vtotal_o  <= '0;
            vsstart_o <= '0;
            vvstart_o <= '0;
            vvend_o   <= '0;
        end else begin
            frame_o <= 1'b0;
            case (r_state)
                SEEK: begin
                    if (w_vs_fall) r_state <= RUN;
                end
                RUN: begin
                    if (w_timeout) begin
                        r_state  <= SEEK;
                        r_match  <= 4'd0;
                        locked_o <= 1'b0;
                    end else if (w_vs_fall) begin
                        htotal_o  <= r_sh_htotal;
                        hsstart_o <= r_sh_hsstart;
                        hvstart_o <= r_sh_hvstart;
                        hvend_o   <= r_sh_hvend;
                        vtotal_o  <= y_o;
                        vsstart_o <= r_sh_vsstart;
                        vvstart_o <= r_sh_vvstart;
                        vvend_o   <= r_sh_vvend;
                        frame_o   <= 1'b1;
                        r_match   <= w_match_nx;
                        locked_o  <= (w_match_nx == C_LOCK);
                    end
                end
                default: r_state <= SEEK;
            endcase
        end
    end

endmodule

// File: tb/tb_sync_analyzer.sv
// Scoreboard bench for sync_analyzer: a crtc-like generator drives sync/enable,
// expected publishes are queued ahead and checked whenever frame_o fires.
module tb_sync_analyzer;
    localparam int W = 10;

    logic         clk = 1'b0, rst_n = 1'b0;
    logic         hs = 1'b0, vs = 1'b0, hd = 1'b0, vd = 1'b0;
    logic [W-1:0] x, y, ht_o, hss_o, hvs_o, hve_o, vt_o, vss_o, vvs_o, vve_o;
    logic         frame, locked;
    logic [101:0] w_all;

    typedef struct packed {
        logic [W-1:0] ht, hss, hvs, hve, vt, vss, vvs, vve;
        logic         lk;
    } pub_t;

    pub_t exp_q[$];
    pub_t m_got, m_exp;
    int   checks = 0, failures = 0;
    int   p_ht, p_hss, p_hvs, p_hve, p_vt, p_vss, p_vvs, p_vve;

    sync_analyzer #(.W(W), .LOCK_FRAMES(2)) dut (
        .dotclk_i(clk), .reset_ni(rst_n),
        .hsync_i(hs), .vsync_i(vs), .hden_i(hd), .vden_i(vd),
        .x_o(x), .y_o(y),
        .htotal_o(ht_o), .hsstart_o(hss_o), .hvstart_o(hvs_o), .hvend_o(hve_o),
        .vtotal_o(vt_o), .vsstart_o(vss_o), .vvstart_o(vvs_o), .vvend_o(vve_o),
        .frame_o(frame), .locked_o(locked)
    );

    always #5 clk = ~clk;

    assign w_all = {x, y, ht_o, hss_o, hvs_o, hve_o, vt_o, vss_o, vvs_o, vve_o, frame, locked};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_timing(input int ht, hss, hvs, hve, vt, vss, vvs, vve);
        p_ht = ht; p_hss = hss; p_hvs = hvs; p_hve = hve;
        p_vt = vt; p_vss = vss; p_vvs = vvs; p_vve = vve;
    endtask

    // One dot of crtc output: sync high from its start offset to the end of the line/frame.
    task automatic drive_dot(input int hc, input int vc);
        @(negedge clk);
        hs = (hc >= p_hss);
        vs = (vc >= p_vss);
        hd = (hc >= p_hvs) && (hc < p_hve);
        vd = (vc >= p_vvs) && (vc < p_vve);
    endtask

    task automatic run_frame();
        for (int vc = 0; vc <= p_vt; vc++)
            for (int hc = 0; hc <= p_ht; hc++)
                drive_dot(hc, vc);
    endtask

    task automatic drive_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            hs = 1'b0; vs = 1'b0; hd = 1'b0; vd = 1'b0;
        end
    endtask

    task automatic push(input int ht, hss, hvs, hve, vt, vss, vvs, vve, input logic lk);
        pub_t p;
        p.ht = W'(ht); p.hss = W'(hss); p.hvs = W'(hvs); p.hve = W'(hve);
        p.vt = W'(vt); p.vss = W'(vss); p.vvs = W'(vvs); p.vve = W'(vve);
        p.lk = lk;
        exp_q.push_back(p);
    endtask

    always @(posedge clk) begin
        #1;
        if (frame === 1'b1) begin
            m_got = {ht_o, hss_o, hvs_o, hve_o, vt_o, vss_o, vvs_o, vve_o, locked};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_frame actual=%h expected=none", m_got);
            end else begin
                m_exp = exp_q.pop_front();
                if (m_got !== m_exp) begin
                    failures++;
                    $display("FAIL publish actual=%h expected=%h", m_got, m_exp);
                end
            end
        end
    end

    initial begin
        set_timing(5, 3, 0, 0, 3, 2, 0, 0);
        drive_idle(2);
        check("reset_state", w_all, 0);
        rst_n = 1'b1;

        // Run partway into a frame, then hit reset between edges.
        for (int i = 0; i < 20; i++) drive_dot(i % 6, i / 6);
        #2 rst_n = 1'b0;
        #1 check("async_reset", w_all, 0);
        hs = 1'b0; vs = 1'b0; hd = 1'b0; vd = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1 check("x_count_after_reset", x, i);
        end

        // No display enables: only sync-derived fields are non-zero.
        push(5, 3, 0, 0, 3, 2, 0, 0, 1'b0);
        run_frame();
        run_frame();
        drive_idle(1);
        @(negedge clk);

        rst_n = 1'b0;
        drive_idle(2);
        check("reset_clears_published", w_all, 0);
        rst_n = 1'b1;

        // hden on dots 2..4, vden on lines 1..2; lock on the 4th vs fall.
        set_timing(5, 3, 2, 5, 3, 2, 1, 3);
        push(5, 3, 2, 5, 3, 2, 1, 3, 1'b0);
        push(5, 3, 2, 5, 3, 2, 1, 3, 1'b0);
        push(5, 3, 2, 5, 3, 2, 1, 3, 1'b1);
        for (int f = 0; f < 4; f++) run_frame();

        // htotal 5->4: hden now ends on the last dot, so its fall coincides with hs fall (x_nx=0).
        set_timing(4, 3, 2, 5, 3, 2, 1, 3);
        push(4, 3, 2, 0, 3, 2, 1, 3, 1'b0);
        push(4, 3, 2, 0, 3, 2, 1, 3, 1'b0);
        push(4, 3, 2, 0, 3, 2, 1, 3, 1'b1);
        for (int f = 0; f < 3; f++) run_frame();

        // Dead sync: first idle dot publishes the last frame, then x runs to saturation.
        drive_idle(1030);
        check("timeout_x_saturated", x, 1023);
        check("timeout_y_held", y, 0);
        check("timeout_unlocked", locked, 0);
        check("timeout_no_frame", frame, 0);

        // Resume: first vs fall only re-arms, next two publish with a fresh match count.
        push(4, 3, 2, 0, 3, 2, 1, 3, 1'b0);
        push(4, 3, 2, 0, 3, 2, 1, 3, 1'b1);
        for (int f = 0; f < 3; f++) run_frame();
        drive_idle(4);
        check("all_publishes_seen", exp_q.size(), 0);
        check("final_locked", locked, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
